// File: rtl/pll_dyn_pkg.sv
// Shared types and helpers for the rPLL dynamic-divider controller.
// Holds the FSM state set, default select codes and counter sizing.
package pll_dyn_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT,
        RELEASE,
        RUN,
        FAIL
    } state_t;

    localparam logic [5:0] PLL_DEF_IDSEL  = 6'd59;
    localparam logic [5:0] PLL_DEF_FBDSEL = 6'd27;
    localparam logic [5:0] PLL_DEF_ODSEL  = 6'd60;

    // Counter width able to hold a terminal value of 'limit'
    function automatic int cnt_w(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/rst_stagger.sv
// Staggered release chain for downstream resets.
// Bit 0 drops on start, each further bit STAGGER cycles later.
module rst_stagger
    import pll_dyn_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int STAGGER = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [NUM_CH-1:0] rst_out,
    output logic              done
);

    localparam int SC_W = cnt_w(STAGGER);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STAGGER - 1);
    localparam logic [NUM_CH-1:0] ALL_ONES = {NUM_CH{1'b1}};

    logic [SC_W-1:0] cnt;
    logic            busy;

    assign busy = (rst_out != ALL_ONES) && (rst_out != '0);
    assign done = (rst_out == '0);

    // Shift zeros in from bit 0 once per STAGGER cycles while releasing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_out <= ALL_ONES;
            cnt     <= '0;
        end else if (abort) begin
            rst_out <= ALL_ONES;
            cnt     <= '0;
        end else if (start) begin
            rst_out <= ALL_ONES << 1;
            cnt     <= '0;
        end else if (busy) begin
            if (cnt == STEP_LAST) begin
                rst_out <= rst_out << 1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Run-time controller for a Gowin rPLL with dynamic divider selects.
// Sequences PLL reset, lock qualification, retries and reset release.
module pll_dyn_ctrl
    import pll_dyn_pkg::*;
#(
    parameter int               NUM_CH       = 2,
    parameter int               SEL_W        = 6,
    parameter logic [SEL_W-1:0] DEF_IDSEL    = SEL_W'(PLL_DEF_IDSEL),
    parameter logic [SEL_W-1:0] DEF_FBDSEL   = SEL_W'(PLL_DEF_FBDSEL),
    parameter logic [SEL_W-1:0] DEF_ODSEL    = SEL_W'(PLL_DEF_ODSEL),
    parameter int               RESET_CYCLES = 16,
    parameter int               LOCK_STABLE  = 256,
    parameter int               LOCK_TIMEOUT = 65535,
    parameter int               STAGGER      = 8,
    parameter int               MAX_RETRY    = 3
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SEL_W-1:0]  cfg_idsel,
    input  logic [SEL_W-1:0]  cfg_fbdsel,
    input  logic [SEL_W-1:0]  cfg_odsel,
    output logic              pll_reset,
    output logic [SEL_W-1:0]  pll_idsel,
    output logic [SEL_W-1:0]  pll_fbdsel,
    output logic [SEL_W-1:0]  pll_odsel,
    input  logic              pll_lock,
    output logic              locked,
    output logic              fail,
    output logic [1:0]        retry_cnt,
    output logic [NUM_CH-1:0] rst_out
);

    localparam int HC_W = cnt_w(RESET_CYCLES);
    localparam int SB_W = cnt_w(LOCK_STABLE);
    localparam int TM_W = cnt_w(LOCK_TIMEOUT);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RESET_CYCLES - 1);
    localparam logic [SB_W-1:0] STAB_LAST = SB_W'(LOCK_STABLE - 1);
    localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(LOCK_TIMEOUT - 1);

    state_t          state;
    logic            lock_m;
    logic            lock_s;
    logic [HC_W-1:0] hold_cnt;
    logic [SB_W-1:0] stab_cnt;
    logic [TM_W-1:0] tmo_cnt;
    logic            accept;
    logic            qualified;
    logic            stg_start;
    logic            stg_abort;
    logic            stg_done;

    assign accept    = cfg_valid && cfg_ready;
    assign qualified = lock_s && (stab_cnt == STAB_LAST);

    // Bring the asynchronous LOCK pin into the clkin domain
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // Start the release chain on qualification, abort it on any restart
    always_comb begin
        stg_start = 1'b0;
        stg_abort = 1'b0;
        if (accept) begin
            stg_abort = 1'b1;
        end else if (state == WAIT) begin
            stg_start = qualified;
        end else if (state == RELEASE || state == RUN) begin
            stg_abort = !lock_s;
        end
    end

    rst_stagger #(
        .NUM_CH  (NUM_CH),
        .STAGGER (STAGGER)
    ) u_stagger (
        .clk     (clkin),
        .rst     (reset),
        .start   (stg_start),
        .abort   (stg_abort),
        .rst_out (rst_out),
        .done    (stg_done)
    );

    // Main sequencer: reset hold, lock wait, release, run and failure
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            pll_reset  <= 1'b1;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
            locked     <= 1'b0;
            fail       <= 1'b0;
            cfg_ready  <= 1'b0;
            retry_cnt  <= 2'd0;
            hold_cnt   <= '0;
            stab_cnt   <= '0;
            tmo_cnt    <= '0;
        end else if (accept) begin
            state      <= HOLD;
            pll_idsel  <= cfg_idsel;
            pll_fbdsel <= cfg_fbdsel;
            pll_odsel  <= cfg_odsel;
            pll_reset  <= 1'b1;
            locked     <= 1'b0;
            fail       <= 1'b0;
            cfg_ready  <= 1'b0;
            retry_cnt  <= 2'd0;
            hold_cnt   <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= WAIT;
                        pll_reset <= 1'b0;
                        hold_cnt  <= '0;
                        stab_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
                    tmo_cnt  <= tmo_cnt + 1'b1;
                    if (qualified) begin
                        state <= RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        pll_reset <= 1'b1;
                        hold_cnt  <= '0;
                        if (!(&retry_cnt)) begin
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                        if (int'(retry_cnt) + 1 > MAX_RETRY) begin
                            state     <= FAIL;
                            fail      <= 1'b1;
                            cfg_ready <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state     <= HOLD;
                        pll_reset <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (stg_done) begin
                        state     <= RUN;
                        locked    <= 1'b1;
                        cfg_ready <= 1'b1;
                        retry_cnt <= 2'd0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= HOLD;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                        pll_reset <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Run-time controller for a Gowin rPLL using dynamic divider selection (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true").
- Accepts divider reconfiguration requests over a valid/ready handshake, drives the rPLL RESET and IDSEL/FBDSEL/ODSEL pins, and qualifies LOCK with stability filtering, timeout and bounded retry.
- Sequences NUM_CH downstream reset releases after lock is qualified.
- Runs on the 27 MHz reference clock, the same clock that feeds rPLL CLKIN, so it stays alive while the PLL output is invalid.

Parameters:
- NUM_CH, 2: number of staggered downstream reset outputs (1..8).
- SEL_W, 6: width of each divider select code.
- DEF_IDSEL, 6'd59: IDSEL code after reset (raw rPLL pin code).
- DEF_FBDSEL, 6'd27: FBDSEL code after reset.
- DEF_ODSEL, 6'd60: ODSEL code after reset.
- RESET_CYCLES, 16: clkin cycles pll_reset is held high per attempt (>=2).
- LOCK_STABLE, 256: consecutive synced-lock-high cycles required to qualify lock.
- LOCK_TIMEOUT, 65535: WAIT_LOCK cycles before an attempt is declared failed.
- STAGGER, 8: clkin cycles between successive rst_out releases.
- MAX_RETRY, 3: failed attempts allowed before entering FAIL.

Ports:
- clkin  in  1  reference clock (27 MHz); also routed to rPLL CLKIN.
- reset  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
- cfg_idsel  in  SEL_W  requested IDSEL code.
- cfg_fbdsel  in  SEL_W  requested FBDSEL code.
- cfg_odsel  in  SEL_W  requested ODSEL code.
- pll_reset  out  1  to rPLL RESET.
- pll_idsel  out  SEL_W  to rPLL IDSEL.
- pll_fbdsel  out  SEL_W  to rPLL FBDSEL.
- pll_odsel  out  SEL_W  to rPLL ODSEL.
- pll_lock  in  1  rPLL LOCK; asynchronous.
- locked  out  1  qualified lock; all rst_out released.
- fail  out  1  retries exhausted.
- retry_cnt  out  2  failed attempts in the current sequence, saturating at 3.
- rst_out  out  NUM_CH  active-high downstream resets; bit i releases i*STAGGER cycles after bit 0.

Behaviour:
- Lock synchronisation: pll_lock passes through a 2-flop synchroniser (lock_s). All lock decisions use lock_s only.
- Reset state:
  - FSM = HOLD; pll_reset=1; pll_*sel = DEF_*; rst_out = all ones.
  - locked=0, fail=0, cfg_ready=0, retry_cnt=0; all counters 0.
- HOLD:
  - pll_reset=1; rst_out all ones; locked=0.
  - Count RESET_CYCLES, then go to WAIT, clearing the timeout and stable counters.
- WAIT:
  - pll_reset=0.
  - Stable counter increments while lock_s=1 and clears to 0 on any lock_s=0.
  - Stable counter reaching LOCK_STABLE goes to RELEASE. Success is checked before timeout in the same cycle.
  - Timeout counter reaching LOCK_TIMEOUT: retry_cnt++. If the new value is <= MAX_RETRY, go to HOLD; otherwise go to FAIL.
- RELEASE:
  - Clear rst_out[0] on entry. Clear the next bit every STAGGER cycles.
  - After the last bit clears, go to RUN on the following cycle.
  - lock_s=0 here: set rst_out all ones and go to HOLD. retry_cnt is unchanged.
- RUN:
  - locked=1; cfg_ready=1; retry_cnt cleared to 0 on entry.
  - lock_s=0: locked=0 and rst_out all ones in the next cycle, then go to HOLD. Loss of lock is not counted as a retry.
- Handshake:
  - On accept (RUN or FAIL), latch cfg_* into pll_*sel in the same edge, go to HOLD, and clear retry_cnt and fail.
  - cfg_ready=0 in every other state; requests there are ignored and not queued.
  - pll_*sel change only on accept, so they are stable throughout HOLD/WAIT.
- FAIL:
  - fail=1; pll_reset=1; rst_out all ones; locked=0; cfg_ready=1.
  - Leaves only on an accepted request.
- Output timing: all outputs are registered.
- Counter widths: each counter is $clog2 of its limit plus 1. Terminal compares are equality on the registered counter.
- Mid-operation reset: asserting reset during any state returns immediately (asynchronously) to reset values, including DEF_* codes.

Decomposition:
- Package pll_dyn_pkg:
  - FSM state enum {HOLD, WAIT, RELEASE, RUN, FAIL}.
  - Default select-code constants.
  - Function computing counter width from a limit.
- Sub-module rst_stagger: NUM_CH shift-release chain with start/abort inputs. Instantiated once.
- The 2-flop synchroniser stays inline.

Test Plan:
- Power-up, pll_lock tied high from cycle 5 → pll_reset high for 16 cycles; locked=1 at 16+2+256 cycles plus release time; rst_out[1] clears 8 cycles after rst_out[0].
- In RUN, cfg_valid with idsel=4, fbdsel=36, odsel=4 → cfg_ready drops next cycle; pll_idsel/fbdsel/odsel = 4/36/4; pll_reset re-asserts for 16 cycles; rst_out all ones, then relock sequence completes.
- pll_lock never asserts, LOCK_TIMEOUT=100 → retry_cnt steps 1, 2, 3; fail=1 after the 4th timeout; cfg_ready=1 in FAIL; a new request clears fail and retry_cnt.
- pll_lock glitches low for 1 cycle at stable count 200 → stable counter restarts; locked delayed by the glitch position plus 256 cycles.
- In RUN, pll_lock drops → locked=0 and rst_out all ones within 3 cycles (sync + register); HOLD entered; retry_cnt stays 0.
- reset pulsed mid-RELEASE with rst_out partially cleared → all outputs return to reset values immediately; pll_*sel = DEF_* codes.
